// File: rtl/pong_pkg.sv
// Shared pong definitions: board coordinate width, paddle FSM states and the
// centre/limit helpers used to derive paddle positions.
package pong_pkg;

  localparam int PONG_COORD_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } paddle_state_e;

  function automatic int paddle_center(input int game_height, input int paddle_height);
    return (game_height - paddle_height) / 2;
  endfunction

  function automatic int paddle_ymax(input int game_height, input int paddle_height);
    return game_height - paddle_height;
  endfunction

endpackage

// File: rtl/pong_paddle_multi_ctrl_if.sv
// Paddle controller bus: button/board-position inputs towards the controller,
// draw flags and paddle rows back to the renderer.
interface pong_paddle_multi_ctrl_if
  import pong_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int COORD_W     = PONG_COORD_W
);

  logic [COORD_W-1:0]             i_col_count_div;
  logic [COORD_W-1:0]             i_row_count_div;
  logic [NUM_PADDLES-1:0]         i_paddle_up;
  logic [NUM_PADDLES-1:0]         i_paddle_down;
  logic                           i_center;
  logic [NUM_PADDLES-1:0]         o_draw_paddle;
  logic                           o_draw_any;
  logic [NUM_PADDLES*COORD_W-1:0] o_paddle_y;

  modport master (
    output i_col_count_div, i_row_count_div, i_paddle_up, i_paddle_down, i_center,
    input  o_draw_paddle, o_draw_any, o_paddle_y
  );

  modport slave (
    input  i_col_count_div, i_row_count_div, i_paddle_up, i_paddle_down, i_center,
    output o_draw_paddle, o_draw_any, o_paddle_y
  );

endinterface

// File: rtl/pong_paddle_channel.sv
// One paddle: button synchroniser, step/auto-repeat FSM, clamped y register and
// draw compare. Build with PONG_PADDLE_ACCEL_EN to halve the repeat period after ACCEL_STEPS repeats.
module pong_paddle_channel
  import pong_pkg::*;
#(
  parameter int                 COORD_W       = PONG_COORD_W,
  parameter int                 GAME_HEIGHT   = 30,
  parameter int                 PADDLE_HEIGHT = 6,
  parameter logic [COORD_W-1:0] PADDLE_COL    = '0,
  parameter int                 REPEAT_DELAY  = 12500000,
  parameter int                 REPEAT_PERIOD = 1250000,
  parameter int                 ACCEL_STEPS   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] row,
  input  logic               up,
  input  logic               down,
  input  logic               center,
  output logic               draw,
  output logic               draw_hit,
  output logic [COORD_W-1:0] y
);

  localparam int                 CNT_W       = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [CNT_W-1:0]   DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [COORD_W-1:0] Y_CENTER    = COORD_W'(paddle_center(GAME_HEIGHT, PADDLE_HEIGHT));
  localparam logic [COORD_W-1:0] Y_MAX       = COORD_W'(paddle_ymax(GAME_HEIGHT, PADDLE_HEIGHT));
  localparam logic [COORD_W:0]   HEIGHT_EXT  = (COORD_W + 1)'(PADDLE_HEIGHT);

  logic               up_meta_r;
  logic               up_sync_r;
  logic               down_meta_r;
  logic               down_sync_r;
  paddle_state_e      state_r;
  paddle_state_e      state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [CNT_W-1:0]   reload_s;
  logic               step_s;
  logic               dir_up_r;
  logic [COORD_W-1:0] y_r;
  logic [COORD_W-1:0] y_nxt_s;
  logic               draw_r;
  logic               req_up_s;
  logic               req_down_s;
  logic               req_s;
  logic               reverse_s;
  logic               expired_s;

  // Two-flop synchronisers for the raw button pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_meta_r   <= 1'b0;
      up_sync_r   <= 1'b0;
      down_meta_r <= 1'b0;
      down_sync_r <= 1'b0;
    end else begin
      up_meta_r   <= up;
      up_sync_r   <= up_meta_r;
      down_meta_r <= down;
      down_sync_r <= down_meta_r;
    end
  end

  // Both buttons pressed cancel each other out
  assign req_up_s   = up_sync_r & ~down_sync_r;
  assign req_down_s = down_sync_r & ~up_sync_r;
  assign req_s      = req_up_s | req_down_s;
  assign reverse_s  = req_s & (req_up_s != dir_up_r);
  assign expired_s  = (cnt_r == {CNT_W{1'b0}});

`ifdef PONG_PADDLE_ACCEL_EN
  localparam int               REP_W     = $clog2(ACCEL_STEPS + 1);
  localparam logic [REP_W-1:0] REP_MAX   = REP_W'(ACCEL_STEPS);
  localparam logic [CNT_W-1:0] FAST_LOAD = CNT_W'(REPEAT_PERIOD / 2 - 1);

  logic [REP_W-1:0] rep_r;
  logic [REP_W-1:0] rep_inc_s;
  logic [REP_W-1:0] rep_nxt_s;

  // Saturating repeat count; the HOLD expiry counts as the first repeat
  always_comb begin
    rep_inc_s = (rep_r == REP_MAX) ? rep_r : rep_r + REP_W'(1);
    reload_s  = (rep_inc_s >= REP_MAX) ? FAST_LOAD : PERIOD_LOAD;
    if (center || !req_s || reverse_s || (state_r == IDLE)) begin
      rep_nxt_s = {REP_W{1'b0}};
    end else if (expired_s) begin
      rep_nxt_s = rep_inc_s;
    end else begin
      rep_nxt_s = rep_r;
    end
  end

  // Repeat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_r <= {REP_W{1'b0}};
    end else begin
      rep_r <= rep_nxt_s;
    end
  end
`else
  assign reload_s = PERIOD_LOAD;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; recentre overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (center) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = req_s ? HOLD : IDLE;
        HOLD:    state_nxt_s = !req_s ? IDLE : (reverse_s ? HOLD : (expired_s ? REPEAT : HOLD));
        REPEAT:  state_nxt_s = !req_s ? IDLE : (reverse_s ? HOLD : REPEAT);
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM outputs: step strobe and next repeat-timer value
  always_comb begin
    step_s    = 1'b0;
    cnt_nxt_s = cnt_r;
    if (center) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            step_s    = 1'b1;
            cnt_nxt_s = DELAY_LOAD;
          end else begin
            cnt_nxt_s = {CNT_W{1'b0}};
          end
        end
        HOLD, REPEAT: begin
          if (!req_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
          end else if (reverse_s) begin
            step_s    = 1'b1;
            cnt_nxt_s = DELAY_LOAD;
          end else if (expired_s) begin
            step_s    = 1'b1;
            cnt_nxt_s = reload_s;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
        default: cnt_nxt_s = {CNT_W{1'b0}};
      endcase
    end
  end

  // Step direction always follows the live request, so clamping never touches timing
  always_comb begin
    if (center) begin
      y_nxt_s = Y_CENTER;
    end else if (!step_s) begin
      y_nxt_s = y_r;
    end else if (req_up_s) begin
      y_nxt_s = (y_r != {COORD_W{1'b0}}) ? y_r - COORD_W'(1) : y_r;
    end else begin
      y_nxt_s = (y_r != Y_MAX) ? y_r + COORD_W'(1) : y_r;
    end
  end

  // Datapath registers: timer, direction memory, paddle row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      dir_up_r <= 1'b0;
      y_r      <= Y_CENTER;
    end else begin
      cnt_r    <= cnt_nxt_s;
      dir_up_r <= req_s ? req_up_s : dir_up_r;
      y_r      <= y_nxt_s;
    end
  end

  // Extra bit keeps y+PADDLE_HEIGHT from wrapping near the board edge
  assign draw_hit = (col == PADDLE_COL) &&
                    ({1'b0, row} >= {1'b0, y_r}) &&
                    ({1'b0, row} < ({1'b0, y_r} + HEIGHT_EXT));

  // Registered draw flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_r <= 1'b0;
    end else begin
      draw_r <= draw_hit;
    end
  end

  assign draw = draw_r;
  assign y    = y_r;

endmodule

// File: rtl/pong_paddle_multi_ctrl.sv
// N-player paddle controller top: one pong_paddle_channel per paddle plus the
// registered any-paddle draw flag. PONG_PADDLE_ACCEL_EN enables repeat acceleration.
module pong_paddle_multi_ctrl
  import pong_pkg::*;
#(
  parameter int                             NUM_PADDLES   = 2,
  parameter int                             COORD_W       = PONG_COORD_W,
  parameter int                             GAME_HEIGHT   = 30,
  parameter int                             PADDLE_HEIGHT = 6,
  parameter logic [NUM_PADDLES*COORD_W-1:0] PADDLE_X      = {6'd39, 6'd0},
  parameter int                             REPEAT_DELAY  = 12500000,
  parameter int                             REPEAT_PERIOD = 1250000,
  parameter int                             ACCEL_STEPS   = 8
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  pong_paddle_multi_ctrl_if.slave bus
);

  logic [NUM_PADDLES-1:0]         draw_s;
  logic [NUM_PADDLES-1:0]         hit_s;
  logic [NUM_PADDLES*COORD_W-1:0] y_s;
  logic                           draw_any_r;

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_paddle
    pong_paddle_channel #(
      .COORD_W       (COORD_W),
      .GAME_HEIGHT   (GAME_HEIGHT),
      .PADDLE_HEIGHT (PADDLE_HEIGHT),
      .PADDLE_COL    (PADDLE_X[g*COORD_W +: COORD_W]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .ACCEL_STEPS   (ACCEL_STEPS)
    ) u_channel (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .col      (bus.i_col_count_div),
      .row      (bus.i_row_count_div),
      .up       (bus.i_paddle_up[g]),
      .down     (bus.i_paddle_down[g]),
      .center   (bus.i_center),
      .draw     (draw_s[g]),
      .draw_hit (hit_s[g]),
      .y        (y_s[g*COORD_W +: COORD_W])
    );
  end

  // OR of the unregistered hits so o_draw_any lines up with o_draw_paddle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      draw_any_r <= 1'b0;
    end else begin
      draw_any_r <= |hit_s;
    end
  end

  assign bus.o_draw_paddle = draw_s;
  assign bus.o_draw_any    = draw_any_r;
  assign bus.o_paddle_y    = y_s;

endmodule
